// File: rtl/emg_pkg.sv
// Shared types, widths and helpers for the EMG receive-side decoder.
package emg_pkg;

  localparam int unsigned EMG_W = 18;
  localparam int unsigned ACC_W = 36;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} burst_state_t;

  // Clamp a signed accumulator value into the unsigned 18-bit envelope range.
  function automatic logic [EMG_W-1:0] sat_u18(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])
      return '0;
    else if (|v[ACC_W-2:EMG_W])
      return '1;
    else
      return v[EMG_W-1:0];
  endfunction

endpackage

// File: rtl/emg_if.sv
// Sample-in / envelope-and-burst-out bundle of the EMG decoder.
interface emg_if
  import emg_pkg::*;
#(
  parameter int unsigned NN = 8
) ();

  logic signed [EMG_W-1:0] i_emg;
  logic                    i_valid;
  logic [EMG_W-1:0]        o_env;
  logic [NN:0]             o_spk_est;
  logic                    o_valid;
  logic                    o_active;
  logic                    o_onset;
  logic                    o_offset;

  modport master (
    output i_emg, i_valid,
    input  o_env, o_spk_est, o_valid, o_active, o_onset, o_offset
  );

  modport slave (
    input  i_emg, i_valid,
    output o_env, o_spk_est, o_valid, o_active, o_onset, o_offset
  );

endinterface

// File: rtl/emg_env_filter.sv
// Two-stage envelope detector: full-wave rectify, then first-order IIR low-pass.
module emg_env_filter
  import emg_pkg::*;
#(
  parameter int unsigned LP_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [EMG_W-1:0] i_emg,
  input  logic                    i_valid,
  output logic [EMG_W-1:0]        o_env,
  output logic                    o_valid
);

  logic [EMG_W-1:0]        rect_d, rect_q;
  logic                    v1_q;
  logic signed [ACC_W-1:0] env_d, env_q, env_nx, rect_ext;
  logic [EMG_W-1:0]        o_env_q;
  logic                    o_valid_q;

  // Most-negative code has no positive twin; clamp it instead of wrapping.
  always_comb begin
    rect_d = '0;
    if (i_emg == {1'b1, {(EMG_W-1){1'b0}}})
      rect_d = {1'b0, {(EMG_W-1){1'b1}}};
    else if (i_emg[EMG_W-1])
      rect_d = EMG_W'(-i_emg);
    else
      rect_d = EMG_W'(i_emg);
  end

  assign rect_ext = ACC_W'(rect_q);
  assign env_nx   = env_q - (env_q >>> LP_SHIFT) + (rect_ext >>> LP_SHIFT);

  always_comb begin
    env_d = env_q;
    if (v1_q)
      env_d = env_nx[ACC_W-1] ? '0 : env_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rect_q    <= '0;
      v1_q      <= 1'b0;
      env_q     <= '0;
      o_env_q   <= '0;
      o_valid_q <= 1'b0;
    end else begin
      if (i_valid)
        rect_q <= rect_d;
      v1_q      <= i_valid;
      env_q     <= env_d;
      o_valid_q <= v1_q;
      if (v1_q)
        o_env_q <= sat_u18(env_d);
    end
  end

  assign o_env   = o_env_q;
  assign o_valid = o_valid_q;

endmodule

// File: rtl/emg_decoder.sv
// EMG receive path: envelope filter, spike-rate estimate and hysteretic burst detector.
module emg_decoder
  import emg_pkg::*;
#(
  parameter int unsigned      NN       = 8,
  parameter int unsigned      LP_SHIFT = 2,
  parameter int unsigned      GAIN_SH  = 7,
  parameter logic [EMG_W-1:0] ON_TH    = 18'd512,
  parameter logic [EMG_W-1:0] OFF_TH   = 18'd256,
  parameter int unsigned      HOLD     = 4
) (
  input  logic clk,
  input  logic reset,
  emg_if.slave bus
);

  localparam int unsigned      SPK_W  = NN + 1;
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

  logic [EMG_W-1:0] env;
  logic             env_vld;
  logic [EMG_W-1:0] spk_full;

  emg_env_filter #(.LP_SHIFT(LP_SHIFT)) u_filter (
    .clk     (clk),
    .reset   (reset),
    .i_emg   (bus.i_emg),
    .i_valid (bus.i_valid),
    .o_env   (env),
    .o_valid (env_vld)
  );

  // Undo the x128 synthesis gain; a pure shift/clamp of the registered envelope.
  assign spk_full      = env >> GAIN_SH;
  assign bus.o_spk_est = (|spk_full[EMG_W-1:SPK_W]) ? '1 : spk_full[SPK_W-1:0];
  assign bus.o_env     = env;
  assign bus.o_valid   = env_vld;

  burst_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             above_on, below_off;
  logic             onset_d, offset_d, active_d;
  logic             onset_q, offset_q, active_q;

  assign above_on  = (env >= ON_TH);
  assign below_off = (env < OFF_TH);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onset_q  <= 1'b0;
      offset_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onset_q  <= onset_d;
      offset_q <= offset_d;
      active_q <= active_d;
    end
  end

  // Only fresh envelope samples advance the burst machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (env_vld) begin
      case (state_q)
        IDLE: begin
          if (above_on) begin
            state_d = ARMING;
            cnt_d   = CNT_W'(1);
          end
        end
        ARMING: begin
          if (!above_on) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc >= HOLD_C) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ACTIVE: begin
          if (below_off) begin
            state_d = RELEASING;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASING: begin
          if (!below_off) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else if (cnt_inc >= HOLD_C) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    onset_d  = 1'b0;
    offset_d = 1'b0;
    active_d = 1'b0;
    if ((state_q == ARMING) && (state_d == ACTIVE))
      onset_d = 1'b1;
    if ((state_q == RELEASING) && (state_d == IDLE))
      offset_d = 1'b1;
    if ((state_d == ACTIVE) || (state_d == RELEASING))
      active_d = 1'b1;
  end

  assign bus.o_onset  = onset_q;
  assign bus.o_offset = offset_q;
  assign bus.o_active = active_q;

endmodule

// File: tb/tb_emg_decoder.sv
// Randomized and directed bench for emg_decoder against a sample-level behavioural model.
module tb_emg_decoder;
  import emg_pkg::*;

  localparam int unsigned NN       = 8;
  localparam int unsigned LP_SHIFT = 2;
  localparam int unsigned GAIN_SH  = 7;
  localparam int          ON_TH    = 512;
  localparam int          OFF_TH   = 256;
  localparam int          HOLD     = 4;
  localparam int          SPK_MAX  = (1 << (NN + 1)) - 1;
  // Confirmation needs at least two samples even when HOLD is 1.
  localparam int          RUN_REQ  = (HOLD < 2) ? 2 : HOLD;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  emg_if #(.NN(NN)) bus ();

  emg_decoder #(
    .NN(NN), .LP_SHIFT(LP_SHIFT), .GAIN_SH(GAIN_SH),
    .ON_TH(18'(ON_TH)), .OFF_TH(18'(OFF_TH)), .HOLD(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_env, m_run;
  bit m_act;
  int onset_seen, offset_seen;
  bit active_seen;

  int q_env[$];
  bit q_vld[$];
  bit q_act[$];
  bit q_on[$];
  bit q_off[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Envelope output lags a driven sample by two edges, burst outputs by three.
  task automatic model_reset();
    m_env = 0;
    m_run = 0;
    m_act = 1'b0;
    q_env = {0, 0};
    q_vld = {1'b0, 1'b0};
    q_act = {1'b0, 1'b0, 1'b0};
    q_on  = {1'b0, 1'b0, 1'b0};
    q_off = {1'b0, 1'b0, 1'b0};
  endtask

  task automatic cycle(input bit v, input int x);
    int e_env, e_spk, rect;
    bit e_on, e_off;
    @(negedge clk);
    e_env = q_env.pop_front();
    e_spk = e_env >> GAIN_SH;
    if (e_spk > SPK_MAX) e_spk = SPK_MAX;
    check("o_env", bus.o_env, e_env);
    check("o_spk_est", bus.o_spk_est, e_spk);
    check("o_valid", bus.o_valid, q_vld.pop_front());
    check("o_active", bus.o_active, q_act.pop_front());
    check("o_onset", bus.o_onset, q_on.pop_front());
    check("o_offset", bus.o_offset, q_off.pop_front());
    if (bus.o_onset) onset_seen++;
    if (bus.o_offset) offset_seen++;
    if (bus.o_active) active_seen = 1'b1;

    bus.i_valid = v;
    bus.i_emg   = EMG_W'(x);
    e_on  = 1'b0;
    e_off = 1'b0;
    if (v) begin
      if (x == -131072) rect = 131071;
      else if (x < 0)   rect = -x;
      else              rect = x;
      m_env = m_env - (m_env >> LP_SHIFT) + (rect >> LP_SHIFT);
      // Count consecutive qualifying samples; a break restarts the count.
      if (!m_act) begin
        m_run = (m_env >= ON_TH) ? m_run + 1 : 0;
        if (m_run >= RUN_REQ) begin
          m_act = 1'b1; m_run = 0; e_on = 1'b1;
        end
      end else begin
        m_run = (m_env < OFF_TH) ? m_run + 1 : 0;
        if (m_run >= RUN_REQ) begin
          m_act = 1'b0; m_run = 0; e_off = 1'b1;
        end
      end
    end
    q_env.push_back(m_env);
    q_vld.push_back(v);
    q_act.push_back(m_act);
    q_on.push_back(e_on);
    q_off.push_back(e_off);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    reset       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_emg   = '0;
    #1;
    check("rst_env", bus.o_env, 0);
    check("rst_spk", bus.o_spk_est, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_active", bus.o_active, 0);
    check("rst_onset", bus.o_onset, 0);
    check("rst_offset", bus.o_offset, 0);
    check("rst_state", longint'(dut.state_q), longint'(IDLE));
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    onset_seen  = 0;
    offset_seen = 0;
    active_seen = 1'b0;
  endtask

  initial begin
    int amp, len, off0, on0;
    bus.i_valid = 1'b0;
    bus.i_emg   = '0;
    model_reset();
    apply_reset();

    // Positive DC step settles to the input level.
    repeat (200) cycle(1'b1, 1024);
    check("t1_env", bus.o_env, 1024);
    check("t1_spk", bus.o_spk_est, 8);

    // Negative step rectifies to the same envelope; full-scale negative does not wrap.
    apply_reset();
    repeat (200) cycle(1'b1, -1024);
    check("t2_env", bus.o_env, 1024);
    repeat (150) cycle(1'b1, -131072);
    check("t2_fullscale", bus.o_env, 131068);
    check("t2_spk_sat", bus.o_spk_est, SPK_MAX);

    // One burst: exactly one onset and one offset.
    apply_reset();
    repeat (100) cycle(1'b1, 2048);
    check("t3_active_mid", bus.o_active, 1);
    repeat (100) cycle(1'b1, 0);
    check("t3_onsets", onset_seen, 1);
    check("t3_offsets", offset_seen, 1);
    check("t3_active_end", bus.o_active, 0);

    // Envelope above ON_TH for only three samples: no burst.
    apply_reset();
    cycle(1'b1, 4000);
    repeat (20) cycle(1'b1, 0);
    check("t4_onsets", onset_seen, 0);
    check("t4_active_seen", active_seen, 0);
    check("t4_state", longint'(dut.state_q), longint'(IDLE));

    // Sparse valid with junk on the data bus in the gaps.
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, (i < 30) ? 2048 : 0);
      repeat (4) cycle(1'b0, int'($urandom_range(0, 262143)) - 131072);
    end
    check("t5_onsets", onset_seen, 1);
    check("t5_offsets", offset_seen, 1);

    // Reset while ACTIVE: silent return to IDLE, then a normal burst.
    apply_reset();
    repeat (30) cycle(1'b1, 2048);
    check("t6_active", bus.o_active, 1);
    apply_reset();
    off0 = offset_seen;
    repeat (20) cycle(1'b1, 0);
    check("t6_no_offset", offset_seen, off0);
    on0 = onset_seen;
    repeat (30) cycle(1'b1, 2048);
    check("t6_reonset", onset_seen, on0 + 1);

    // Random levels, signs, durations and valid density.
    apply_reset();
    for (int s = 0; s < 50; s++) begin
      amp = $urandom_range(0, 6000);
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 15) == 0) amp = 131072;
      for (int k = 0; k < len; k++)
        cycle($urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) != 0) ? -amp : ((amp > 131071) ? 131071 : amp));
    end
    repeat (60) cycle(1'b1, 0);
    check("t7_idle_end", bus.o_active, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
